mem_arb_n: RTL and testbench
============================

# mem_arb_n

N-channel memory-port arbiter that merges `NUM_CH` independent requestors onto one downstream memory port. It is the successor to the core's fixed two-port instruction/data arbiter: it adds parametrised channel count, widths and arbitration mode, plus ownership locking across multi-cycle `mem_busy` stalls. It sits between the pipeline stages (fetch, data, and future DMA/debug masters) and the memory interface.

## Interface
Parameters:
- `NUM_CH`, 2: number of requestor channels (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `ARB_MODE`, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).
- `FETCH_CH`, 0: channel index that drives `fetch`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `ch_r`  in  NUM_CH  per-channel read request.
- `ch_w`  in  NUM_CH  per-channel write request.
- `ch_sz`  in  NUM_CH×2  per-channel access size.
- `ch_addr`  in  NUM_CH×AW  per-channel address.
- `ch_wdata`  in  NUM_CH×DW  per-channel write data.
- `ch_rdata`  out  DW  read data, broadcast to all channels.
- `ch_busy`  out  NUM_CH  per-channel stall.
- `mem_r`, `mem_w`  out  1  downstream read/write strobe.
- `mem_sz`  out  2  downstream size.
- `mem_addr`  out  AW  downstream address.
- `mem_wdata`  out  DW  downstream write data.
- `mem_rdata`  in  DW  downstream read data.
- `mem_busy`  in  1  downstream stall.
- `fetch`  out  1  high when the granted channel is `FETCH_CH`.
- `mem_id`  out  $clog2(NUM_CH)  index of the granted channel.

## Operation
- `req[i] = ch_r[i] | ch_w[i]`.
- States are IDLE and LOCKED.
- IDLE: the winner is picked combinationally among the asserted `req`.
  - Round-robin: search starts at `rr_ptr` and wraps modulo `NUM_CH`.
  - Fixed priority: the lowest index wins.
  - The winner's request is forwarded to `mem_*` in the same cycle.
- If `mem_busy` is 1 in the grant cycle, `owner <= winner` and the state goes to LOCKED.
- LOCKED: `owner` is forwarded unconditionally; other requests are ignored.
- Completion is any cycle in which a channel is forwarded and `mem_busy` is 0. On completion:
  - the state goes to IDLE;
  - round-robin mode sets `rr_ptr <= (granted+1) mod NUM_CH`.
- `ch_busy[i] = req[i] & ~(granted==i & ~mem_busy)`. A non-requesting channel sees `ch_busy` = 0.
- `ch_rdata = mem_rdata`, passed through combinationally. It is valid for a channel in the cycle its `ch_busy` is low.
- Requestors hold their request stable while `ch_busy` is high.
- If the owner drops `req` while LOCKED, this is a protocol violation:
  - `mem_r`/`mem_w` go to 0;
  - the state returns to IDLE on the next edge;
  - `rr_ptr` is unchanged.
- `ch_r` and `ch_w` both high on one channel is forwarded as-is. Downstream behaviour for that case is undefined.
- When no channel is granted, `mem_r`, `mem_w`, `fetch` and `mem_id` are 0, and `mem_addr`, `mem_wdata` and `mem_sz` are 0.

## Timing
- Grant latency is 0 cycles: a request in IDLE reaches `mem_*` combinationally.
- An access with `mem_busy` = 0 completes in 1 cycle.
- Back-to-back: after channel A completes in cycle t, channel B may be granted in cycle t+1. The arbiter adds no bubble.
- Reset values: state IDLE, `rr_ptr` 0, `owner` 0.
- While `rst` is low, `mem_r`, `mem_w`, `fetch`, `mem_id` and `ch_busy` are forced to 0.
- Reset asserted mid-transaction drops the lock immediately.
- A request arriving in the same cycle as a completion is not granted that cycle. It competes in the next cycle, with `rr_ptr` already updated.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - adds output `perf_wait`, NUM_CH×16, one counter per channel;
  - each counter increments when `req[i]` and `ch_busy[i]` and not granted (lost-arbitration cycles only, not downstream stall cycles);
  - counters saturate at 16'hFFFF and clear on reset.
- Undefined: the port and the counters are absent; the block is otherwise identical.

## Structure
- Package `mem_arb_pkg`:
  - `arb_mode_e` (ARB_RR, ARB_FIXED);
  - `arb_state_e` (IDLE, LOCKED);
  - `SZ_W = 2`.
- Sub-module `arb_rr_pick`: a combinational N-way rotating priority picker. Inputs are `req` and `ptr`; outputs are `valid` and `idx`. Fixed-priority mode reuses it with `ptr = 0`.

## Test plan
- NUM_CH=2, RR, both channels request reads, `mem_busy` = 0 → grants alternate 0,1,0,1 on consecutive cycles; `ch_busy` toggles complementarily.
- Channel 0 write to `addr` 0x100 with `mem_busy` high for 3 cycles, channel 1 requests in cycle 1 → `mem_addr` stays 0x100 for 4 cycles, `ch_busy[1]` = 1 throughout; channel 1 is granted in cycle 4.
- ARB_MODE=1, NUM_CH=4, channels 1 and 3 request continuously → channel 1 always wins and channel 3 starves; with `MEM_ARB_PERF_EN`, `perf_wait[3]` counts every cycle.
- NUM_CH=4, RR, `rr_ptr`=3, channels 0 and 3 request → 3 wins, then 0 (wrap-around).
- `rst` pulled low during a LOCKED access → `mem_r` drops the same cycle; after release the state is IDLE and `rr_ptr` = 0.
- Owner drops its request while LOCKED → `mem_r`/`mem_w` = 0; IDLE next cycle; a waiting channel is granted the cycle after.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the N-channel memory arbiter
package mem_arb_pkg;

  // Width of the per-access size field carried alongside each request.
  localparam int SZ_W = 2;

  typedef enum logic [0:0] {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Next index after v in a ring of n slots.
  function automatic int ring_next(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// rtl/arb_rr_pick.sv - combinational rotating-priority picker over N requests
module arb_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  localparam logic [IW:0] NV = (IW+1)'(N);

  logic [IW:0] j;

  // Walk from the farthest offset back to ptr so the closest asserted
  // request (in ring order starting at ptr) is the one left standing.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= NV) j = j - NV;
      if (req[j[IW-1:0]]) begin
        valid = 1'b1;
        idx   = j[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arb_n.sv
// rtl/mem_arb_n.sv - N-channel memory-port arbiter with stall locking (optional MEM_ARB_PERF_EN wait counters)
module mem_arb_n
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int ARB_MODE = 0,
  parameter int FETCH_CH = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_r,
  input  logic [NUM_CH-1:0]        ch_w,
  input  logic [NUM_CH*SZ_W-1:0]   ch_sz,
  input  logic [NUM_CH*AW-1:0]     ch_addr,
  input  logic [NUM_CH*DW-1:0]     ch_wdata,
  output logic [DW-1:0]            ch_rdata,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic                     mem_r,
  output logic                     mem_w,
  output logic [SZ_W-1:0]          mem_sz,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_busy,
  output logic                     fetch,
  output logic [$clog2(NUM_CH)-1:0] mem_id
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_CH*16-1:0]     perf_wait
`endif
);

  localparam int IW = $clog2(NUM_CH);

  localparam logic [0:0]    ST_IDLE   = IDLE;
  localparam logic [0:0]    ST_LOCKED = LOCKED;
  localparam logic [IW-1:0] FETCH_IDX = IW'(FETCH_CH);
  localparam bit            MODE_RR   = (ARB_MODE == int'(ARB_RR));

  logic [NUM_CH-1:0] req;
  logic [0:0]        state;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     pick_ptr;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic [IW-1:0]     granted;
  logic              gnt_valid;
  logic              complete;

  assign req      = ch_r | ch_w;
  assign ch_rdata = mem_rdata;

  // Fixed priority is just the rotating picker anchored at channel 0.
  assign pick_ptr = MODE_RR ? rr_ptr : '0;

  arb_rr_pick #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Resolve who owns the port this cycle: the lock holder if locked (only
  // while it still requests), otherwise the picker's winner; nobody in reset.
  always_comb begin
    granted   = pick_idx;
    gnt_valid = pick_valid;
    if (state == ST_LOCKED) begin
      granted   = owner;
      gnt_valid = req[owner];
    end
    if (!rst) gnt_valid = 1'b0;
  end

  assign complete = gnt_valid & ~mem_busy;

  // Forward the granted channel's request downstream; all zero when idle.
  always_comb begin
    mem_r     = 1'b0;
    mem_w     = 1'b0;
    mem_sz    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gnt_valid && granted == IW'(i)) begin
        mem_r     = ch_r[i];
        mem_w     = ch_w[i];
        mem_sz    = ch_sz[i*SZ_W +: SZ_W];
        mem_addr  = ch_addr[i*AW +: AW];
        mem_wdata = ch_wdata[i*DW +: DW];
      end
    end
    mem_id = gnt_valid ? granted : '0;
    fetch  = gnt_valid && (granted == FETCH_IDX);
  end

  // A requester stalls unless it is the granted channel and memory accepts.
  always_comb begin
    ch_busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = rst & req[i] & ~(gnt_valid && granted == IW'(i) && !mem_busy);
    end
  end

  // Lock the port to the winner across downstream stalls; release on
  // completion or when the owner abandons its request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      owner <= '0;
    end else if (state == ST_IDLE) begin
      if (gnt_valid && mem_busy) begin
        state <= ST_LOCKED;
        owner <= granted;
      end
    end else if (!gnt_valid || !mem_busy) begin
      state <= ST_IDLE;
    end
  end

  // Advance the round-robin origin past whoever just completed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (complete && MODE_RR) begin
      rr_ptr <= IW'(ring_next(int'(granted), NUM_CH));
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_cnt [NUM_CH];

  // Count cycles lost to arbitration only; downstream stalls of the
  // granted channel are not charged to it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) perf_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (req[i] && ch_busy[i] && !(gnt_valid && granted == IW'(i)) &&
            perf_cnt[i] != 16'hFFFF) begin
          perf_cnt[i] <= perf_cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
    assign perf_wait[g*16 +: 16] = perf_cnt[g];
  end
`endif

endmodule

// File: tb/tb_mem_arb_n.sv
// tb/tb_mem_arb_n.sv - randomized and directed bench for mem_arb_n (RR and fixed-priority instances)
`timescale 1ns/1ps
module tb_mem_arb_n;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: round-robin instance (FETCH_CH=1); index 1: fixed-priority instance (FETCH_CH=0)
  logic [3:0]   r_in [2];
  logic [3:0]   w_in [2];
  logic [7:0]   sz_in [2];
  logic [127:0] addr_in [2];
  logic [127:0] wd_in [2];
  logic         mb_in [2];
  logic [31:0]  mrd;

  logic [31:0]  crd_o [2];
  logic [31:0]  maddr_o [2];
  logic [31:0]  mwd_o [2];
  logic [3:0]   cb_o [2];
  logic         mr_o [2];
  logic         mw_o [2];
  logic         f_o [2];
  logic [1:0]   sz_o [2];
  logic [1:0]   id_o [2];
`ifdef MEM_ARB_PERF_EN
  logic [63:0]  pw_o [2];
`endif

  mem_arb_n #(.NUM_CH(4), .AW(32), .DW(32), .ARB_MODE(0), .FETCH_CH(1)) u_rr (
    .clk(clk), .rst(rst),
    .ch_r(r_in[0]), .ch_w(w_in[0]), .ch_sz(sz_in[0]), .ch_addr(addr_in[0]), .ch_wdata(wd_in[0]),
    .ch_rdata(crd_o[0]), .ch_busy(cb_o[0]),
    .mem_r(mr_o[0]), .mem_w(mw_o[0]), .mem_sz(sz_o[0]), .mem_addr(maddr_o[0]), .mem_wdata(mwd_o[0]),
    .mem_rdata(mrd), .mem_busy(mb_in[0]), .fetch(f_o[0]), .mem_id(id_o[0])
`ifdef MEM_ARB_PERF_EN
    , .perf_wait(pw_o[0])
`endif
  );

  mem_arb_n #(.NUM_CH(4), .AW(32), .DW(32), .ARB_MODE(1), .FETCH_CH(0)) u_fx (
    .clk(clk), .rst(rst),
    .ch_r(r_in[1]), .ch_w(w_in[1]), .ch_sz(sz_in[1]), .ch_addr(addr_in[1]), .ch_wdata(wd_in[1]),
    .ch_rdata(crd_o[1]), .ch_busy(cb_o[1]),
    .mem_r(mr_o[1]), .mem_w(mw_o[1]), .mem_sz(sz_o[1]), .mem_addr(maddr_o[1]), .mem_wdata(mwd_o[1]),
    .mem_rdata(mrd), .mem_busy(mb_in[1]), .fetch(f_o[1]), .mem_id(id_o[1])
`ifdef MEM_ARB_PERF_EN
    , .perf_wait(pw_o[1])
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: who holds the port, where the rotation starts, wait counts.
  bit          chk_en = 1'b0;
  bit          m_locked [2];
  int          m_owner [2];
  int          m_ptr [2];
  bit          m_hold [2][4];
  logic [15:0] m_perf [2][4];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        int g;
        int start;
        int idx;
        int fch;
        logic [3:0] req;
        logic [3:0] eb;
        req = r_in[d] | w_in[d];
        fch = (d == 0) ? 1 : 0;
        chk($sformatf("u%0d_ch_rdata", d), crd_o[d], mrd);
        if (!rst) begin
          chk($sformatf("u%0d_rst_mem_r", d), mr_o[d], 0);
          chk($sformatf("u%0d_rst_mem_w", d), mw_o[d], 0);
          chk($sformatf("u%0d_rst_fetch", d), f_o[d], 0);
          chk($sformatf("u%0d_rst_mem_id", d), id_o[d], 0);
          chk($sformatf("u%0d_rst_ch_busy", d), cb_o[d], 0);
          m_locked[d] = 1'b0;
          m_owner[d]  = 0;
          m_ptr[d]    = 0;
          for (int i = 0; i < 4; i++) begin
            m_perf[d][i] = '0;
            m_hold[d][i] = 1'b0;
          end
        end else begin
          g = -1;
          if (m_locked[d]) begin
            if (req[m_owner[d]]) g = m_owner[d];
          end else begin
            start = (d == 1) ? 0 : m_ptr[d];
            for (int k = 0; k < 4; k++) begin
              idx = (start + k) % 4;
              if (g < 0 && req[idx]) g = idx;
            end
          end
          for (int i = 0; i < 4; i++) eb[i] = req[i] && !(g == i && !mb_in[d]);
          chk($sformatf("u%0d_ch_busy", d), cb_o[d], eb);
          chk($sformatf("u%0d_mem_r", d), mr_o[d], (g >= 0) ? r_in[d][g] : 1'b0);
          chk($sformatf("u%0d_mem_w", d), mw_o[d], (g >= 0) ? w_in[d][g] : 1'b0);
          chk($sformatf("u%0d_mem_sz", d), sz_o[d], (g >= 0) ? sz_in[d][g*2 +: 2] : 2'b0);
          chk($sformatf("u%0d_mem_addr", d), maddr_o[d], (g >= 0) ? addr_in[d][g*32 +: 32] : 32'b0);
          chk($sformatf("u%0d_mem_wdata", d), mwd_o[d], (g >= 0) ? wd_in[d][g*32 +: 32] : 32'b0);
          chk($sformatf("u%0d_mem_id", d), id_o[d], (g >= 0) ? g : 0);
          chk($sformatf("u%0d_fetch", d), f_o[d], (g == fch) ? 1'b1 : 1'b0);
`ifdef MEM_ARB_PERF_EN
          for (int i = 0; i < 4; i++) begin
            chk($sformatf("u%0d_perf_wait%0d", d, i), pw_o[d][i*16 +: 16], m_perf[d][i]);
            if (req[i] && eb[i] && g != i && m_perf[d][i] != 16'hFFFF) m_perf[d][i] = m_perf[d][i] + 16'd1;
          end
`endif
          for (int i = 0; i < 4; i++) m_hold[d][i] = eb[i];
          if (g >= 0 && !mb_in[d]) begin
            m_locked[d] = 1'b0;
            if (d == 0) m_ptr[d] = (g + 1) % 4;
          end else if (g >= 0 && !m_locked[d]) begin
            m_locked[d] = 1'b1;
            m_owner[d]  = g;
          end else if (g < 0) begin
            m_locked[d] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    mrd = $urandom;
  endtask

  task automatic drv(input int d, input int i, input bit rd, input bit wr, input logic [31:0] a);
    r_in[d][i] = rd;
    w_in[d][i] = wr;
    addr_in[d][i*32 +: 32] = a;
    wd_in[d][i*32 +: 32]   = $urandom;
    sz_in[d][i*2 +: 2]     = 2'($urandom_range(0, 3));
  endtask

  task automatic clr(input int d);
    r_in[d] = '0; w_in[d] = '0; sz_in[d] = '0; addr_in[d] = '0; wd_in[d] = '0;
  endtask

  initial begin
    rst = 1'b0;
    mrd = '0;
    clr(0); clr(1);
    mb_in[0] = 1'b0; mb_in[1] = 1'b0;
    #1 chk_en = 1'b1;

    // reset forces outputs even with a live request
    drv(0, 0, 1, 0, 32'h40);
    #1;
    chk("reset_mem_r", mr_o[0], 0);
    chk("reset_ch_busy", cb_o[0], 0);
    tick();
    rst = 1'b1;
    clr(0);

    // two readers, no stall: grants alternate 0,1,0,1
    drv(0, 0, 1, 0, 32'h10);
    drv(0, 1, 1, 0, 32'h20);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_mem_id", id_o[0], k % 2);
      chk("alt_ch_busy", cb_o[0], (k % 2) ? 4'b0001 : 4'b0010);
      tick();
    end
    clr(0);

    // ch0 write to 0x100 stalled 3 cycles, ch1 arrives in cycle 1
    drv(0, 0, 0, 1, 32'h100);
    mb_in[0] = 1'b1;
    #1 chk("lock_addr_c0", maddr_o[0], 32'h100);
    tick();
    drv(0, 1, 1, 0, 32'h200);
    #1;
    chk("lock_addr_c1", maddr_o[0], 32'h100);
    chk("lock_busy1_c1", cb_o[0][1], 1);
    tick();
    #1;
    chk("lock_addr_c2", maddr_o[0], 32'h100);
    chk("lock_busy1_c2", cb_o[0][1], 1);
    tick();
    mb_in[0] = 1'b0;
    #1;
    chk("lock_addr_c3", maddr_o[0], 32'h100);
    chk("lock_busy1_c3", cb_o[0][1], 1);
    chk("lock_busy0_c3", cb_o[0][0], 0);
    tick();
    drv(0, 0, 0, 0, 32'h0);
    #1;
    chk("lock_next_id", id_o[0], 1);
    chk("lock_next_busy1", cb_o[0][1], 0);
    tick();
    clr(0);

    // rotation pointer at 3, channels 0 and 3 compete: 3 then 0
    drv(0, 2, 1, 0, 32'h300);
    #1 chk("wrap_setup_id", id_o[0], 2);
    tick();
    clr(0);
    drv(0, 0, 1, 0, 32'h400);
    drv(0, 3, 1, 0, 32'h500);
    #1 chk("wrap_first", id_o[0], 3);
    tick();
    #1 chk("wrap_second", id_o[0], 0);
    tick();
    clr(0);

    // reset during a locked access, then the pointer must be back at 0
    drv(0, 1, 1, 0, 32'h600);
    tick();
    clr(0);
    drv(0, 2, 1, 0, 32'h700);
    mb_in[0] = 1'b1;
    #1 chk("rlock_id", id_o[0], 2);
    tick();
    #1 chk("rlock_mem_r", mr_o[0], 1);
    rst = 1'b0;
    #1 chk("rlock_drop_mem_r", mr_o[0], 0);
    tick();
    rst = 1'b1;
    mb_in[0] = 1'b0;
    clr(0);
    drv(0, 1, 1, 0, 32'h800);
    drv(0, 2, 1, 0, 32'h900);
    #1 chk("rlock_after_ptr0", id_o[0], 1);
    tick();
    clr(0);

    // owner abandons its request while locked
    drv(0, 0, 0, 1, 32'hA00);
    mb_in[0] = 1'b1;
    #1 chk("drop_id0", id_o[0], 0);
    tick();
    drv(0, 3, 1, 0, 32'hB00);
    #1;
    chk("drop_locked_id", id_o[0], 0);
    chk("drop_wait_busy3", cb_o[0][3], 1);
    tick();
    drv(0, 0, 0, 0, 32'h0);
    mb_in[0] = 1'b0;
    #1;
    chk("drop_mem_r", mr_o[0], 0);
    chk("drop_mem_w", mw_o[0], 0);
    chk("drop_busy3", cb_o[0][3], 1);
    tick();
    #1;
    chk("drop_next_id", id_o[0], 3);
    chk("drop_next_mem_r", mr_o[0], 1);
    chk("drop_next_busy3", cb_o[0][3], 0);
    tick();
    clr(0);

    // fixed priority: channel 1 always beats channel 3
    drv(1, 1, 1, 0, 32'hC00);
    drv(1, 3, 1, 0, 32'hD00);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fix_mem_id", id_o[1], 1);
      chk("fix_ch_busy", cb_o[1], 4'b1000);
      tick();
    end
`ifdef MEM_ARB_PERF_EN
    #1;
    chk("fix_perf3", pw_o[1][63:48], 6);
    chk("fix_perf1", pw_o[1][31:16], 0);
`endif
    clr(1);

    // random traffic: requesters hold while stalled, occasional reset pulses
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      for (int d = 0; d < 2; d++) begin
        mb_in[d] = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 4; i++) begin
          if (!m_hold[d][i]) begin
            int pick;
            pick = $urandom_range(0, 3);
            drv(d, i, pick == 1, pick == 2, $urandom);
          end
        end
      end
      tick();
    end

    rst = 1'b1;
    clr(0); clr(1);
    tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
